ssem_sequencer: RTL and testbench
=================================

SSEM_SEQUENCER -- requirements
Module: ssem_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the bus and data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, command offered.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accepted when high together with cmd_valid.
REQ-006 The block SHALL have port cmd_op, input, 3, opcode: 000 LOAD_A, 001 LOAD_B, 010 ADD, 011 SUB, 100 READ_A, 101 READ_B, 110/111 illegal.
REQ-007 The block SHALL have port cmd_data, input, DATA_W, operand for LOAD ops.
REQ-008 The block SHALL have port rsp_valid, output, 1, response available.
REQ-009 The block SHALL have port rsp_ready, input, 1, response consumed when high together with rsp_valid.
REQ-010 The block SHALL have port rsp_data, output, DATA_W, captured bus value.
REQ-011 The block SHALL have port rsp_err, output, 1, response is for an illegal opcode.
REQ-012 The block SHALL have outputs load_A, load_B, a_to_bus, b_to_bus, alu_sub, alu_latch and alu_to_bus, each 1 bit, the datapath control lines.
REQ-013 The block SHALL have port bus_out, output, DATA_W, value driven onto the datapath bus.
REQ-014 The block SHALL have port bus_drive, output, 1, tristate enable for bus_out.
REQ-015 The block SHALL have port bus_in, input, DATA_W, the sampled datapath bus.
REQ-016 The block SHALL have port op_count, output, 16, number of completed commands.

Function
REQ-017 The block SHALL have five states: IDLE, WRITE, LATCH, READ and RESP; control outputs are decoded from the registered state only (Moore).
REQ-018 cmd_ready SHALL be 1 in IDLE only; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, and cmd_op/cmd_data are registered at that edge.
REQ-019 A LOAD_A or LOAD_B command SHALL transition IDLE->WRITE->IDLE; in WRITE: bus_drive=1, bus_out=the registered data, and load_A or load_B=1 for exactly one cycle; no response is produced.
REQ-020 An ADD or SUB command SHALL transition IDLE->LATCH->READ->RESP.
REQ-021 In LATCH, alu_latch=1 and alu_sub=0 for ADD or 1 for SUB.
REQ-022 In READ for ADD/SUB, alu_to_bus=1 and alu_sub holds its LATCH value.
REQ-023 A READ_A or READ_B command SHALL transition IDLE->READ->RESP, with a_to_bus or b_to_bus=1 in READ.
REQ-024 rsp_data SHALL capture bus_in on the edge that ends READ; rsp_err=0 for legal ops.
REQ-025 An illegal opcode SHALL transition IDLE->RESP with rsp_data=0 and rsp_err=1; no control line or bus_drive asserts.
REQ-026 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL be stable until the rsp_valid&rsp_ready edge, then go to IDLE; RESP is held indefinitely while rsp_ready=0.
REQ-027 Latencies SHALL be: LOAD acceptance to next cmd_ready = 2 cycles; ADD/SUB acceptance to rsp_valid = 3 cycles; READ_x = 2 cycles; illegal = 1 cycle.
REQ-028 At most one of bus_drive, a_to_bus, b_to_bus and alu_to_bus SHALL be 1 in any cycle; all are 0 in IDLE, LATCH and RESP.
REQ-029 op_count SHALL increment by 1 on leaving WRITE and on the RESP handshake (including illegal ops), wrapping from 0xFFFF to 0x0000.
REQ-030 rsp_valid SHALL never depend combinationally on rsp_ready, and cmd_ready SHALL never depend combinationally on cmd_valid.

Reset
REQ-031 While reset=1 at an edge, the state SHALL become IDLE and all control outputs, bus_drive, rsp_valid, rsp_err, rsp_data, bus_out and op_count SHALL become 0; cmd_ready=1 from the first cycle after reset deasserts.
REQ-032 Reset asserted in any state mid-command SHALL abort that command with no response, and every control line SHALL be 0 in the following cycle.

Verification
REQ-033 LOAD_A 0x00000005, then LOAD_B 0x00000003, then ADD, with the bench modelling the datapath -> one load_A pulse with bus_out=5, one load_B pulse with bus_out=3, rsp_data=0x00000008, op_count=3.
REQ-034 After the loads in REQ-033, SUB -> alu_sub=1 in LATCH and READ, rsp_data=0x00000002, rsp_err=0.
REQ-035 cmd_op=111 -> rsp_valid one cycle after acceptance, rsp_err=1, rsp_data=0, and no bus or control activity.
REQ-036 READ_B with rsp_ready held at 0 for 10 cycles -> rsp_valid and rsp_data stable throughout, cmd_ready=0, and completion on the first rsp_ready=1 edge.
REQ-037 reset pulsed during LATCH of an ADD -> no response, all outputs 0, and a subsequent LOAD_A is accepted normally.
REQ-038 0x10000 back-to-back LOAD_A commands from reset -> op_count wraps to 0x0000, and the exclusivity of REQ-028 holds on every cycle.

Source files
------------

// File: rtl/ssem_sequencer.sv
// Command sequencer for a small accumulator-style datapath: decodes LOAD/ADD/SUB/READ
// commands into one-hot bus control lines and returns READ/ALU results as responses.
module ssem_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              load_A,
    output logic              load_B,
    output logic              a_to_bus,
    output logic              b_to_bus,
    output logic              alu_sub,
    output logic              alu_latch,
    output logic              alu_to_bus,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    input  logic [DATA_W-1:0] bus_in,
    output logic [15:0]       op_count
);

    localparam logic [2:0] OP_LOAD_A = 3'b000;
    localparam logic [2:0] OP_LOAD_B = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_READ_A = 3'b100;
    localparam logic [2:0] OP_READ_B = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_LATCH,
        S_READ,
        S_RESP
    } state_t;

    typedef struct packed {
        logic cmd_ready;
        logic load_a;
        logic load_b;
        logic a_to_bus;
        logic b_to_bus;
        logic alu_sub;
        logic alu_latch;
        logic alu_to_bus;
        logic bus_drive;
        logic rsp_valid;
    } ctrl_t;

    // Moore decode; evaluated on the next state so every control line comes straight from a flop.
    function automatic ctrl_t decode(input state_t st, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_IDLE:  c.cmd_ready = 1'b1;
            S_WRITE: begin
                c.bus_drive = 1'b1;
                c.load_a    = (op == OP_LOAD_A);
                c.load_b    = (op == OP_LOAD_B);
            end
            S_LATCH: begin
                c.alu_latch = 1'b1;
                c.alu_sub   = (op == OP_SUB);
            end
            S_READ: begin
                c.a_to_bus   = (op == OP_READ_A);
                c.b_to_bus   = (op == OP_READ_B);
                c.alu_to_bus = (op == OP_ADD) || (op == OP_SUB);
                c.alu_sub    = (op == OP_SUB);
            end
            S_RESP:  c.rsp_valid = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    ctrl_t               ctrl_q;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [15:0]         count_q, count_d;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bus_out_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_LOAD_A, OP_LOAD_B: begin
                            state_d   = S_WRITE;
                            bus_out_d = cmd_data;
                        end
                        OP_ADD, OP_SUB:       state_d = S_LATCH;
                        OP_READ_A, OP_READ_B: state_d = S_READ;
                        default: begin
                            state_d    = S_RESP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                count_d = count_q + 16'd1;
            end
            S_LATCH: state_d = S_READ;
            S_READ: begin
                state_d    = S_RESP;
                rsp_data_d = bus_in;
                rsp_err_d  = 1'b0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            ctrl_q     <= decode(S_IDLE, '0);
            bus_out_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ctrl_q     <= decode(state_d, op_d);
            bus_out_q  <= bus_out_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            count_q    <= count_d;
        end
    end

    assign cmd_ready  = ctrl_q.cmd_ready;
    assign rsp_valid  = ctrl_q.rsp_valid;
    assign load_A     = ctrl_q.load_a;
    assign load_B     = ctrl_q.load_b;
    assign a_to_bus   = ctrl_q.a_to_bus;
    assign b_to_bus   = ctrl_q.b_to_bus;
    assign alu_sub    = ctrl_q.alu_sub;
    assign alu_latch  = ctrl_q.alu_latch;
    assign alu_to_bus = ctrl_q.alu_to_bus;
    assign bus_drive  = ctrl_q.bus_drive;
    assign bus_out    = bus_out_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_ssem_sequencer.sv
// Scoreboard bench for ssem_sequencer: a register-file datapath model sits on the bus, an
// abstract A/B model predicts responses and load pulses, and a monitor compares them.
module tb_ssem_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          load_A, load_B, a_to_bus, b_to_bus, alu_sub, alu_latch, alu_to_bus;
    logic [DW-1:0] bus_out;
    logic          bus_drive;
    logic [DW-1:0] bus_in;
    logic [15:0]   op_count;

    ssem_sequencer #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .load_A(load_A), .load_B(load_B), .a_to_bus(a_to_bus), .b_to_bus(b_to_bus),
        .alu_sub(alu_sub), .alu_latch(alu_latch), .alu_to_bus(alu_to_bus),
        .bus_out(bus_out), .bus_drive(bus_drive), .bus_in(bus_in), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] ctrl_vec;
    assign ctrl_vec = {load_A, load_B, a_to_bus, b_to_bus, alu_sub, alu_latch, alu_to_bus, bus_drive};

    // Datapath on the far side of the bus: two registers and an ALU latch.
    logic [DW-1:0] dp_a = '0, dp_b = '0, dp_alu = '0;
    always_comb begin
        bus_in = 32'hDEAD_BEEF;
        if (bus_drive)       bus_in = bus_out;
        else if (a_to_bus)   bus_in = dp_a;
        else if (b_to_bus)   bus_in = dp_b;
        else if (alu_to_bus) bus_in = dp_alu;
    end
    always @(posedge clk) begin
        if (load_A)    dp_a   <= bus_in;
        if (load_B)    dp_b   <= bus_in;
        if (alu_latch) dp_alu <= alu_sub ? dp_a - dp_b : dp_a + dp_b;
    end

    // Abstract reference: register contents and expected completions.
    typedef struct packed { logic [DW-1:0] data; logic err; } rsp_t;
    typedef struct packed { logic is_b; logic [DW-1:0] data; } ld_t;
    rsp_t rsp_q[$];
    ld_t  ld_q[$];
    logic [DW-1:0] model_a = '0, model_b = '0;
    logic [15:0]   exp_count = '0;
    int            rsp_mode = 0;

    always begin
        @(posedge clk);
        #1;
        case (rsp_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    rsp_t mon_rsp;
    ld_t  mon_ld;
    always @(negedge clk) begin
        if (!reset) begin
            check("bus_exclusive", ($countones({bus_drive, a_to_bus, b_to_bus, alu_to_bus}) <= 1), 1);
            if (bus_drive && !(load_A || load_B)) check("bus_drive_without_load", bus_drive, 0);
            if (load_A || load_B) begin
                check("load_expected", ld_q.size() > 0, 1);
                if (ld_q.size() > 0) begin
                    mon_ld = ld_q.pop_front();
                    check("load_A_line", load_A, !mon_ld.is_b);
                    check("load_B_line", load_B, mon_ld.is_b);
                    check("load_bus_drive", bus_drive, 1);
                    check("load_bus_out", bus_out, mon_ld.data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", rsp_q.size() > 0, 1);
                if (rsp_q.size() > 0) begin
                    mon_rsp = rsp_q.pop_front();
                    check("rsp_data", rsp_data, mon_rsp.data);
                    check("rsp_err", rsp_err, mon_rsp.err);
                end
            end
        end
    end

    // Issue one command, update the model, and measure latency to cmd_ready (loads) or rsp_valid.
    task automatic send(input logic [2:0] op, input logic [DW-1:0] d);
        int   n;
        int   exp_lat;
        bit   is_load;
        rsp_t r;
        ld_t  l;
        is_load = (op == 3'b000) || (op == 3'b001);
        r.err = 1'b0;
        r.data = '0;
        case (op)
            3'b000: begin model_a = d; l.is_b = 1'b0; l.data = d; ld_q.push_back(l); exp_lat = 2; end
            3'b001: begin model_b = d; l.is_b = 1'b1; l.data = d; ld_q.push_back(l); exp_lat = 2; end
            3'b010: begin r.data = model_a + model_b; exp_lat = 3; end
            3'b011: begin r.data = model_a - model_b; exp_lat = 3; end
            3'b100: begin r.data = model_a; exp_lat = 2; end
            3'b101: begin r.data = model_b; exp_lat = 2; end
            default: begin r.err = 1'b1; exp_lat = 1; end
        endcase
        if (!is_load) rsp_q.push_back(r);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_data = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (alu_latch || alu_to_bus) check("alu_sub_level", alu_sub, op == 3'b011);
        end while (!(is_load ? cmd_ready : rsp_valid) && n < 20);
        check("latency", n, exp_lat);
        if (is_load) exp_count++;
        else begin
            check("resp_cycle_quiet", ctrl_vec, 0);
            check("resp_cmd_ready_low", cmd_ready, 0);
        end
    endtask

    task automatic finish_rsp();
        int n = 0;
        while (!(rsp_valid && rsp_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_handshake_seen", rsp_valid && rsp_ready, 1);
        @(posedge clk);
        #1;
        exp_count++;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, ctrl_vec, 0);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_rsp_err"}, rsp_err, 0);
        check({name, "_rsp_data"}, rsp_data, 0);
        check({name, "_bus_out"}, bus_out, 0);
        check({name, "_op_count"}, op_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]    op;
        logic [DW-1:0] d;
        int            n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        send(3'b000, 32'h0000_0005);
        send(3'b001, 32'h0000_0003);
        send(3'b010, '0);
        finish_rsp();
        check("op_count_after_add", op_count, exp_count);
        send(3'b011, '0);
        finish_rsp();
        check("op_count_after_sub", op_count, exp_count);

        send(3'b111, 32'h1234_5678);
        check("illegal_rsp_err_out", rsp_err, 1);
        check("illegal_rsp_data_out", rsp_data, 0);
        finish_rsp();

        rsp_mode = 1;
        send(3'b101, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, model_b);
            check("hold_rsp_err", rsp_err, 0);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_mode = 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 20);
        check("hold_release_cycles", n, 1);
        @(posedge clk);
        #1;
        exp_count++;
        check("hold_done_rsp_valid", rsp_valid, 0);
        check("hold_done_cmd_ready", cmd_ready, 1);
        rsp_mode = 0;

        send(3'b100, '0);
        finish_rsp();

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            d = $urandom;
            send(op, d);
            if (!(op == 3'b000 || op == 3'b001)) finish_rsp();
        end
        check("op_count_after_random", op_count, exp_count);

        // Abort an ADD with reset while it is in its latch cycle.
        cmd_op = 3'b010;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_latch", alu_latch, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = '0;
        check_all_zero("after_abort");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        send(3'b000, 32'hA5A5_0001);
        check("op_count_after_abort_load", op_count, exp_count);

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = '0;
        for (int i = 0; i < 65536; i++) begin
            send(3'b000, DW'(i) ^ 32'h5A00_0000);
            if (i == 65534) check("op_count_ffff", op_count, 16'hFFFF);
        end
        check("op_count_wrap", op_count, 16'h0000);

        @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 0);
        check("load_queue_empty", ld_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
